// File: rtl/ps2_keyboard_frontend.sv
// rtl/ps2_keyboard_frontend.sv - PS/2 scan-code receiver, dual hex seven-segment decode, power-up ready delay.
// Bytes are taken on synchronised PS/2 falling edges; stalled partial frames are dropped after TIMEOUT_CYCLES.
module ps2_keyboard_frontend #(
  parameter int DELAY_CYCLES   = 1048575,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] key_data,
  output logic       key_pressed,
  output logic       frame_error,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi,
  output logic       ready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = $clog2(DELAY_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state, next_state;
  logic            clk_s1, clk_s2, clk_prev;
  logic            dat_s1, dat_s2;
  logic            ps2_fall;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic            par_bit;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   dcnt;
  logic            frame_ok, frame_bad, timed_out;

  assign ps2_fall = clk_prev & ~clk_s2;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    timed_out  = 1'b0;
    if (state != S_IDLE && !ps2_fall && tcnt == TW'(TIMEOUT_CYCLES)) begin
      next_state = S_IDLE;
      timed_out  = 1'b1;
    end else if (ps2_fall) begin
      case (state)
        S_IDLE:   if (!dat_s2) next_state = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) next_state = S_PARITY;
        S_PARITY: next_state = S_STOP;
        S_STOP: begin
          next_state = S_IDLE;
          // odd parity: data bits plus parity bit must XOR to 1
          if (dat_s2 && (^{shift, par_bit})) frame_ok = 1'b1;
          else                               frame_bad = 1'b1;
        end
        default:  next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      clk_prev    <= 1'b1;
      dat_s1      <= 1'b1;
      dat_s2      <= 1'b1;
      shift       <= 8'h00;
      bit_cnt     <= 3'd0;
      par_bit     <= 1'b0;
      tcnt        <= '0;
      key_data    <= 8'h00;
      key_pressed <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      clk_s1      <= ps2_clock;
      clk_s2      <= clk_s1;
      clk_prev    <= clk_s2;
      dat_s1      <= ps2_data;
      dat_s2      <= dat_s1;
      key_pressed <= frame_ok;
      frame_error <= frame_bad | timed_out;
      if (frame_ok) key_data <= shift;
      if (ps2_fall) begin
        case (state)
          S_IDLE:   bit_cnt <= 3'd0;
          S_DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= dat_s2;
          default:  ;
        endcase
      end
      if (ps2_fall || state == S_IDLE) tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
    end
  end

  // Saturates at DELAY_CYCLES so ready stays high until the next reset.
  always_ff @(posedge clock) begin
    if (reset)                          dcnt <= '0;
    else if (dcnt != DW'(DELAY_CYCLES)) dcnt <= dcnt + 1'b1;
  end

  assign ready = (dcnt == DW'(DELAY_CYCLES));

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign seg_lo = hex_to_seg(key_data[3:0]);
  assign seg_hi = hex_to_seg(key_data[7:4]);

endmodule

// File: tb/tb_ps2_keyboard_frontend.sv
// tb/tb_ps2_keyboard_frontend.sv - randomized and directed bench for ps2_keyboard_frontend against a frame-level model.
module tb_ps2_keyboard_frontend;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_data;
  logic       key_pressed, frame_error;
  logic [6:0] seg_lo, seg_hi;
  logic       ready;

  int passed = 0;
  int total  = 0;
  int kp_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] exp_key = 8'h00;
  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ps2_keyboard_frontend #(.DELAY_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .key_data(key_data), .key_pressed(key_pressed), .frame_error(frame_error),
    .seg_lo(seg_lo), .seg_hi(seg_hi), .ready(ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (key_pressed) kp_cnt++;
    if (frame_error) fe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (8) @(posedge clock);
      ps2_clock = 1'b0;
      repeat (8) @(posedge clock);
      ps2_clock = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    @(negedge clock);
    check_eq({tag, ".key"}, key_data, exp_key);
    check_eq({tag, ".seg_lo"}, seg_lo, seg_ref[exp_key[3:0]]);
    check_eq({tag, ".seg_hi"}, seg_hi, seg_ref[exp_key[7:4]]);
  endtask

  // kind 0: good frame, 1: parity flipped, 2: stop bit low
  task automatic run_frame(input logic [7:0] b, input int kind, input string tag);
    int kp0, fe0;
    logic par, stp;
    kp0 = kp_cnt;
    fe0 = fe_cnt;
    par = ~(^b);
    if (kind == 1) par = ~par;
    stp = (kind == 2) ? 1'b0 : 1'b1;
    send_bits({stp, par, b, 1'b0}, 11);
    repeat (6) @(posedge clock);
    if (kind == 0) exp_key = b;
    check_eq({tag, ".pressed"}, kp_cnt - kp0, (kind == 0) ? 1 : 0);
    check_eq({tag, ".error"}, fe_cnt - fe0, (kind == 0) ? 0 : 1);
    check_outputs(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("ready_drop", ready, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int kp0, fe0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_eq("rst.ready", ready, 0);
    check_outputs("rst");
    for (int i = 2; i <= 16; i++) begin
      @(posedge clock);
      #1;
      if (i == 15) check_eq("ready_early", ready, 0);
      if (i == 16) check_eq("ready_on_time", ready, 1);
    end

    run_frame(8'h1C, 0, "f1C");
    run_frame(8'h1C, 1, "badpar");
    run_frame(8'h1C, 2, "badstop");
    run_frame(8'h1C, 0, "f1C_rep");

    kp0 = kp_cnt;
    fe0 = fe_cnt;
    send_bits(11'b000_0000_1110, 4);
    repeat (130) @(posedge clock);
    check_eq("tmo.error", fe_cnt - fe0, 1);
    check_eq("tmo.pressed", kp_cnt - kp0, 0);
    run_frame(8'hF0, 0, "fF0");

    for (int n = 0; n < 16; n++) run_frame(8'(n * 17), 0, "sweep");

    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      int k;
      b = 8'($urandom_range(0, 255));
      k = $urandom_range(0, 3);
      run_frame(b, (k < 2) ? k : 0, "rand");
    end
    check_eq("ready_hold", ready, 1);

    kp0 = kp_cnt;
    fe0 = fe_cnt;
    send_bits(11'b101_1010_0100, 5);
    pulse_reset();
    exp_key = 8'h00;
    repeat (4) @(posedge clock);
    check_eq("midrst.pressed", kp_cnt - kp0, 0);
    check_eq("midrst.error", fe_cnt - fe0, 0);
    check_outputs("midrst");
    run_frame(8'hA5, 0, "fA5");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
